// File: rtl/tone_controller.sv
// tone_controller: plays one note at a time through a sine_reader.
// It latches a note (phase step and beat count), issues one generate_next per sample tick,
// captures the returned sample and counts beats until the note expires. A request that is
// still in flight when the last beat lands is drained before the note is reported done.
module tone_controller #(
  parameter int unsigned STEP_WIDTH   = 20,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DUR_WIDTH    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play_en,
  input  logic                    load_note,
  input  logic [STEP_WIDTH-1:0]   note_step,
  input  logic [DUR_WIDTH-1:0]    note_duration,
  input  logic                    beat,
  input  logic                    sample_tick,
  input  logic                    sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic [STEP_WIDTH-1:0]   step_size,
  output logic                    generate_next,
  output logic                    note_busy,
  output logic                    done_with_note,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    overrun
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPlay  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic [DUR_WIDTH-1:0]    remaining_q, remaining_d;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    gen_q, gen_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic capture;
  logic pend_eff;
  logic tick_go;
  logic beat_go;
  logic final_beat;

  // Event decode; a sample returning this cycle frees the slot for a coincident tick.
  always_comb begin
    capture    = sample_ready && pending_q;
    pend_eff   = pending_q && !sample_ready;
    tick_go    = sample_tick && play_en;
    beat_go    = beat && play_en;
    final_beat = beat_go && (remaining_q == DUR_WIDTH'(1));
  end

  // Next-state logic for the note sequencer and all registered outputs.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    gen_d       = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        // Idle outputs fall to zero one cycle after the done pulse.
        step_d      = '0;
        sample_d    = '0;
        pending_d   = 1'b0;
        remaining_d = '0;
        if (load_note) begin
          if (note_duration != '0) begin
            step_d      = note_step;
            remaining_d = note_duration;
            state_d     = StPlay;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StPlay: begin
        if (capture) begin
          sample_d  = sample_in;
          valid_d   = 1'b1;
          pending_d = 1'b0;
        end
        if (final_beat) begin
          // The note ends here; a coincident tick is not serviced.
          remaining_d = '0;
          if (pend_eff) begin
            state_d = StDrain;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          if (beat_go && (remaining_q != '0)) begin
            remaining_d = remaining_q - DUR_WIDTH'(1);
          end
          if (tick_go) begin
            if (step_q == '0) begin
              // Rest: emit silence at the sample rate without touching sine_reader.
              sample_d = '0;
              valid_d  = 1'b1;
            end else if (!pend_eff) begin
              gen_d     = 1'b1;
              pending_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end

      StDrain: begin
        if (capture) begin
          sample_d  = sample_in;
          valid_d   = 1'b1;
          pending_d = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      step_q      <= '0;
      remaining_q <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      gen_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      gen_q       <= gen_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    step_size      = step_q;
    generate_next  = gen_q;
    note_busy      = busy_q;
    done_with_note = done_q;
    sample_out     = sample_q;
    sample_valid   = valid_q;
    overrun        = overrun_q;
  end

endmodule
